alu_mul_seq: RTL
================

Name: alu_mul_seq

Overview:
- Sequential unsigned multiplier that drives the shared add/sub ALU as an initiator.
- Accepts operand pairs over a valid/ready request channel.
- Produces each product by issuing one ALU add per cycle in shift-and-add form, then returns the 2*bits product over a valid/ready response channel.
- Sits between the control path and the existing combinational ALU; the ALU itself is external and untouched.

Parameters:
- bits, 8, operand width; product width is 2*bits; iteration count is bits.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  request operands present
- req_ready  out  1  block can accept a request
- req_a  in  bits  multiplicand
- req_b  in  bits  multiplier
- resp_valid  out  1  product available
- resp_ready  in  1  consumer takes product
- resp_p  out  2*bits  product req_a*req_b, unsigned
- alu_ra  out  bits  ALU operand A
- alu_rb  out  bits  ALU operand B
- alu_s  out  1  ALU select; tied 0 (add)
- alu_out  in  bits  ALU sum
- alu_carry  in  1  ALU carry out

Behaviour:
- Clocking and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_p=0, counter=0, acc_hi=0, acc_lo=0, mcand=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: mcand<=req_a, acc_hi<=0, acc_lo<=req_b, count<=0, go to RUN.
- RUN:
  - req_ready=0.
  - Each cycle: alu_ra=acc_hi, alu_rb = acc_lo[0] ? mcand : 0, alu_s=0.
  - Next state: {acc_hi,acc_lo} <= {alu_carry, alu_out, acc_lo[bits-1:1]}.
  - count increments. When count==bits-1, go to DONE after this step (exactly bits RUN cycles).
- DONE:
  - resp_valid=1, resp_p={acc_hi,acc_lo}, held stable while resp_ready=0.
  - On resp_valid&resp_ready: go to IDLE.
- Latency: resp_valid rises bits+1 cycles after the request-accept edge (9 for bits=8).
- Throughput: one product per bits+2 cycles minimum; no request accepted while RUN or DONE.
- Outside RUN, alu_ra/alu_rb=0 and alu_s=0, so the ALU is quiescent.
- ALU usage: the block relies only on combinational add semantics; carry_out is consumed only with alu_s=0. It never selects subtract.
- Width rule:
  - Product fits exactly in 2*bits.
  - 255*255=0xFE01 for bits=8.
  - No overflow indicator.
- Boundary conditions:
  - req_valid while busy: ignored, held off by req_ready=0; no operand capture.
  - Request held across DONE->IDLE: accepted in the first IDLE cycle, not the DONE cycle.
  - resp_ready high before DONE: no effect.
  - rst during RUN or DONE: next cycle IDLE with all reset values; the in-flight product is discarded and no resp_valid pulse occurs.
  - rst and req_valid in the same cycle: rst wins, request not accepted.

Optional Feature:
- Macro: ALU_MUL_ZERO_SKIP_EN
- Defined: in IDLE, an accepted request with req_a==0 or req_b==0 goes directly to DONE with product 0. resp_valid rises 1 cycle after the accept edge; no ALU cycles are issued.
- Undefined: zero operands take the full bits RUN cycles like any other request and still yield product 0.

Test Plan:
- bits=8, req_a=13, req_b=11, resp_ready=1 -> resp_p=0x008F, resp_valid 9 cycles after accept, resp_valid high for exactly 1 cycle.
- req_a=255, req_b=255 -> resp_p=0xFE01; alu_carry=1 observed on at least one RUN step; alu_s=0 throughout.
- resp_ready=0 for 5 cycles after DONE with req_a=200, req_b=3 -> resp_p=0x0258 held stable; req_ready=0 throughout; one transfer when resp_ready rises.
- Back-to-back requests (7*9, then 128*2) with req_valid held continuously -> 0x003F then 0x0100; second accept occurs in the cycle after the first response handshake.
- rst pulsed on 4th RUN cycle of 100*100 -> next cycle IDLE, req_ready=1, resp_valid never asserted; a following 3*5 yields 0x000F.
- req_a=0, req_b=77: with ALU_MUL_ZERO_SKIP_EN -> resp_p=0, latency 1; without it -> resp_p=0, latency 9.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Sequential shift-and-add unsigned multiplier that borrows the shared add/sub ALU, one add per cycle.
// Optional build macro ALU_MUL_ZERO_SKIP_EN: a zero operand skips the RUN phase and returns 0 at once.
module alu_mul_seq #(
    parameter int bits = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [bits-1:0]     req_a,
    input  logic [bits-1:0]     req_b,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [2*bits-1:0]   resp_p,
    output logic [bits-1:0]     alu_ra,
    output logic [bits-1:0]     alu_rb,
    output logic                alu_s,
    input  logic [bits-1:0]     alu_out,
    input  logic                alu_carry
);
    localparam int CW = (bits > 1) ? $clog2(bits) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are both high;
    // valid never depends on ready, and resp_p is held stable while resp_valid waits for resp_ready.
    state_t          state, state_nxt;
    logic [bits-1:0] mcand, acc_hi, acc_lo;
    logic [CW-1:0]   count;
    logic            accept, last_step, zero_op;

    assign accept    = req_valid && req_ready;
    assign last_step = (count == CW'(bits - 1));

`ifdef ALU_MUL_ZERO_SKIP_EN
    assign zero_op = (req_a == '0) || (req_b == '0);
`else
    assign zero_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = zero_op ? DONE : RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (state == IDLE);
        resp_valid = (state == DONE);
        resp_p     = (state == DONE) ? {acc_hi, acc_lo} : '0;
        alu_ra     = '0;
        alu_rb     = '0;
        alu_s      = 1'b0;
        if (state == RUN) begin
            alu_ra = acc_hi;
            alu_rb = acc_lo[0] ? mcand : '0;
        end
    end

    // Accumulator shifts right each step; the ALU sum plus carry becomes the new upper half.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            count  <= '0;
        end else if (state == IDLE && accept) begin
            mcand  <= req_a;
            acc_hi <= '0;
            acc_lo <= zero_op ? '0 : req_b;
            count  <= '0;
        end else if (state == RUN) begin
            {acc_hi, acc_lo} <= {alu_carry, alu_out, acc_lo[bits-1:1]};
            count            <= count + 1'b1;
        end
    end
endmodule
